// File: rtl/f_le_arbiter_pkg.sv
// f_le_arb_pkg: shared types and constants for the f_le comparator arbiter.
// FLEN mirrors the cvw FP configuration (64 for FP64).
package f_le_arb_pkg;

   localparam int FLEN = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RSP  = 2'd2
   } f_le_arb_state_t;

   // Width of a grant index; never below one bit.
   function automatic int grant_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/f_le_arbiter_if.sv
// f_le_arbiter_if: per-requester request/response handshakes of the
// comparator arbiter. The req_lock vector exists only when
// F_LE_ARB_LOCK_EN is defined.
interface f_le_arbiter_if #(
   parameter int N_REQ = 3
);
   import f_le_arb_pkg::*;

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_ready;
   logic [N_REQ-1:0][FLEN-1:0]  req_a;
   logic [N_REQ-1:0][FLEN-1:0]  req_b;
`ifdef F_LE_ARB_LOCK_EN
   logic [N_REQ-1:0]            req_lock;
`endif
   logic [N_REQ-1:0]            rsp_valid;
   logic [N_REQ-1:0]            rsp_ready;
   logic                        rsp_res;
   logic                        rsp_err;

`ifdef F_LE_ARB_LOCK_EN
   // Requester side (the sorting FSMs).
   modport master (
      output req_valid, req_a, req_b, req_lock, rsp_ready,
      input  req_ready, rsp_valid, rsp_res, rsp_err
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_a, req_b, req_lock, rsp_ready,
      output req_ready, rsp_valid, rsp_res, rsp_err
   );
`else
   // Requester side (the sorting FSMs).
   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_res, rsp_err
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_res, rsp_err
   );
`endif

endinterface

// File: rtl/f_le_arbiter_rr_pick.sv
// f_le_rr_pick: combinational round-robin picker. Scans the request vector
// starting one past last_grant with wrap-around; force_en restricts the
// choice to force_idx (used to hold a locked requester).
module f_le_rr_pick
   import f_le_arb_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int GW    = grant_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [GW-1:0]    last_grant,
   input  logic [GW-1:0]    force_idx,
   input  logic             force_en,
   output logic [N_REQ-1:0] gnt,
   output logic [GW-1:0]    gnt_idx,
   output logic             gnt_valid
);

   logic [GW-1:0]    cand_idx [N_REQ];
   logic [N_REQ-1:0] cand_hit;

   // Candidate gi is the requester (gi+1) places after last_grant, modulo N_REQ.
   // The sum is kept one bit wider so the wrap compare cannot overflow.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [GW:0] sum;
      assign sum           = {1'b0, last_grant} + (GW+1)'(gi + 1);
      assign cand_idx[gi]  = (sum >= (GW+1)'(N_REQ)) ? GW'(sum - (GW+1)'(N_REQ))
                                                     : sum[GW-1:0];
      assign cand_hit[gi]  = req[cand_idx[gi]];
   end

   // Nearest candidate wins: scan from farthest to nearest so the nearest overwrites.
   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      if (force_en) begin
         if (req[force_idx]) begin
            gnt_valid      = 1'b1;
            gnt_idx        = force_idx;
            gnt[force_idx] = 1'b1;
         end
      end else begin
         for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
               gnt_valid = 1'b1;
               gnt_idx   = cand_idx[k];
            end
         end
         if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/f_le_arbiter.sv
// f_le_arbiter: shares one f_less_or_equal comparator between N_REQ
// requesters with round-robin arbitration. Each transaction takes
// IDLE (accept) -> CMP (drive comparator, register result) -> RSP (respond).
// Build option F_LE_ARB_LOCK_EN adds req_lock so a requester can keep the
// comparator for several back-to-back transactions.
module f_le_arbiter
   import f_le_arb_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input  logic            clk,
   input  logic            rst,      // asynchronous, active low
   f_le_arbiter_if.slave   bus,
   output logic            busy,
   output logic [FLEN-1:0] f_le_a,
   output logic [FLEN-1:0] f_le_b,
   input  logic            f_le_res,
   input  logic            f_le_err
);

   localparam int            GW       = grant_w(N_REQ);
   // Reset last_grant to the final index so requester 0 is scanned first.
   localparam logic [GW-1:0] LAST_RST = GW'(N_REQ - 1);

   f_le_arb_state_t  state_q, state_d;
   logic [GW-1:0]    last_grant_q, last_grant_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [FLEN-1:0]  op_a_q, op_a_d;
   logic [FLEN-1:0]  op_b_q, op_b_d;
   logic             res_q, res_d;
   logic             err_q, err_d;

   logic [N_REQ-1:0] pick_gnt;
   logic [GW-1:0]    pick_idx;
   logic             pick_valid;
   logic [GW-1:0]    force_idx;
   logic             force_en;

`ifdef F_LE_ARB_LOCK_EN
   logic             locked_q, locked_d;

   // A locked requester is the only one IDLE may grant.
   assign force_en  = locked_q;
   assign force_idx = last_grant_q;
   assign busy      = (state_q != IDLE) || locked_q;
`else
   assign force_en  = 1'b0;
   assign force_idx = '0;
   assign busy      = (state_q != IDLE);
`endif

   f_le_rr_pick #(
      .N_REQ (N_REQ),
      .GW    (GW)
   ) u_pick (
      .req        (bus.req_valid),
      .last_grant (last_grant_q),
      .force_idx  (force_idx),
      .force_en   (force_en),
      .gnt        (pick_gnt),
      .gnt_idx    (pick_idx),
      .gnt_valid  (pick_valid)
   );

   // Next-state and output decode: every output defaults to zero, registers hold.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_d       = grant_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      res_d         = res_q;
      err_d         = err_q;
`ifdef F_LE_ARB_LOCK_EN
      locked_d      = locked_q;
`endif
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      bus.rsp_res   = 1'b0;
      bus.rsp_err   = 1'b0;
      f_le_a        = '0;
      f_le_b        = '0;

      case (state_q)
         IDLE: begin
            // req_ready is combinational; qualify with rst so it is zero in reset.
            if (rst && pick_valid) begin
               bus.req_ready = pick_gnt;
               grant_d       = pick_idx;
               op_a_d        = bus.req_a[pick_idx];
               op_b_d        = bus.req_b[pick_idx];
`ifdef F_LE_ARB_LOCK_EN
               locked_d      = bus.req_lock[pick_idx];
`endif
               state_d       = CMP;
            end
         end
         CMP: begin
            // The comparator is combinational; its result is only sampled here.
            f_le_a  = op_a_q;
            f_le_b  = op_b_q;
            res_d   = f_le_res & ~f_le_err;
            err_d   = f_le_err;
            state_d = RSP;
         end
         RSP: begin
            bus.rsp_valid[grant_q] = 1'b1;
            bus.rsp_res            = res_q;
            bus.rsp_err            = err_q;
            if (bus.rsp_ready[grant_q]) begin
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= LAST_RST;
         grant_q      <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         res_q        <= 1'b0;
         err_q        <= 1'b0;
`ifdef F_LE_ARB_LOCK_EN
         locked_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         res_q        <= res_d;
         err_q        <= err_d;
`ifdef F_LE_ARB_LOCK_EN
         locked_q     <= locked_d;
`endif
      end
   end

endmodule

// File: tb/tb_f_le_arbiter.sv
// tb_f_le_arbiter: directed FP64 cases plus randomized traffic, all checked
// every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_f_le_arbiter;
   import f_le_arb_pkg::*;

   localparam int N = 3;

   localparam logic [63:0] F_ONE   = 64'h3FF0000000000000;
   localparam logic [63:0] F_TWO   = 64'h4000000000000000;
   localparam logic [63:0] F_NAN   = 64'h7FF8000000000000;
   localparam logic [63:0] F_MONE  = 64'hBFF0000000000000;
   localparam logic [63:0] F_ZERO  = 64'h0000000000000000;
   localparam logic [63:0] F_NZERO = 64'h8000000000000000;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            busy;
   logic [FLEN-1:0] f_le_a, f_le_b;
   logic            f_le_res, f_le_err;

   int errors = 0;
   int checks = 0;
   int n_txn  = 0;

   always #5 clk = ~clk;

   f_le_arbiter_if #(.N_REQ(N)) bus();

   f_le_arbiter #(.N_REQ(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .f_le_a   (f_le_a),
      .f_le_b   (f_le_b),
      .f_le_res (f_le_res),
      .f_le_err (f_le_err)
   );

   function automatic logic is_nan(input logic [63:0] x);
      return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
   endfunction

   function automatic logic real_le(input logic [63:0] a, input logic [63:0] b);
      return $bitstoreal(a) <= $bitstoreal(b);
   endfunction

   // Comparator stand-in; res is deliberately 1 on NaN so masking is observable.
   assign f_le_err = is_nan(f_le_a) | is_nan(f_le_b);
   assign f_le_res = f_le_err ? 1'b1 : real_le(f_le_a, f_le_b);

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] rand_op();
      logic [63:0] r;
      case ($urandom_range(0, 7))
         0:       r = F_ONE;
         1:       r = F_TWO;
         2:       r = F_NAN;
         3:       r = F_MONE;
         4:       r = F_ZERO;
         5:       r = F_NZERO;
         6:       r = {$urandom, $urandom};
         default: r = {1'b0, 11'h3FF, 20'($urandom), 32'($urandom)};
      endcase
      return r;
   endfunction

   // ---------------- reference model + per-cycle compare ----------------
   int          cyc = 0;
   bit          m_txn = 1'b0;
   int          m_idx = 0;
   int          m_acc = 0;
   int          m_last = N - 1;
   bit          m_locked = 1'b0;
   logic [63:0] m_a = '0, m_b = '0;
   bit          m_res = 1'b0, m_err = 1'b0;

   initial begin : compare
      logic [N-1:0] exp_ready, exp_rvalid;
      logic [63:0]  exp_a, exp_b;
      logic         exp_res, exp_err, exp_busy;
      int           pick, j;
      forever begin
         @(negedge clk);
         cyc++;
         exp_ready  = '0;
         exp_rvalid = '0;
         exp_a      = '0;
         exp_b      = '0;
         exp_res    = 1'b0;
         exp_err    = 1'b0;
         exp_busy   = 1'b0;
         if (!rst) begin
            m_txn    = 1'b0;
            m_last   = N - 1;
            m_locked = 1'b0;
         end else if (!m_txn) begin
            pick     = -1;
            exp_busy = m_locked;
            if (m_locked) begin
               if (bus.req_valid[m_last]) pick = m_last;
            end else begin
               for (int k = 1; k <= N; k++) begin
                  j = (m_last + k) % N;
                  if (pick < 0 && bus.req_valid[j]) pick = j;
               end
            end
            if (pick >= 0) begin
               exp_ready[pick] = 1'b1;
               m_txn = 1'b1;
               m_idx = pick;
               m_acc = cyc;
               m_a   = bus.req_a[pick];
               m_b   = bus.req_b[pick];
               m_err = is_nan(m_a) | is_nan(m_b);
               m_res = !m_err && real_le(m_a, m_b);
`ifdef F_LE_ARB_LOCK_EN
               m_locked = bus.req_lock[pick];
`endif
            end
         end else if (cyc - m_acc == 1) begin
            exp_a    = m_a;
            exp_b    = m_b;
            exp_busy = 1'b1;
         end else begin
            exp_rvalid[m_idx] = 1'b1;
            exp_res  = m_res;
            exp_err  = m_err;
            exp_busy = 1'b1;
            if (bus.rsp_ready[m_idx]) begin
               m_txn  = 1'b0;
               m_last = m_idx;
               n_txn++;
               $display("txn %0d: req=%0d a=%h b=%h res=%0b err=%0b acc_cyc=%0d rsp_cyc=%0d",
                        n_txn, m_idx, m_a, m_b, m_res, m_err, m_acc, cyc);
            end
         end
         chk("m_req_ready", 64'(bus.req_ready), 64'(exp_ready));
         chk("m_rsp_valid", 64'(bus.rsp_valid), 64'(exp_rvalid));
         chk("m_rsp_res",   64'(bus.rsp_res),   64'(exp_res));
         chk("m_rsp_err",   64'(bus.rsp_err),   64'(exp_err));
         chk("m_f_le_a",    f_le_a,             exp_a);
         chk("m_f_le_b",    f_le_b,             exp_b);
         chk("m_busy",      64'(busy),          64'(exp_busy));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
`ifdef F_LE_ARB_LOCK_EN
      bus.req_lock  = '0;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("rst_busy",      64'(busy),          64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_f_le_a",    f_le_a,             64'd0);
      tick();
      rst = 1'b1;
   endtask

   task automatic single(input int idx, input logic [63:0] a, input logic [63:0] b,
                         input logic exp_res, input logic exp_err);
      logic [N-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      bus.req_valid      = oh;
      bus.req_a[idx]     = a;
      bus.req_b[idx]     = b;
      bus.rsp_ready      = '1;
      @(negedge clk);
      chk("single_accept", 64'(bus.req_ready), 64'(oh));
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      chk("single_cmp_a",     f_le_a,             a);
      chk("single_cmp_rsp",   64'(bus.rsp_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("single_rsp_valid", 64'(bus.rsp_valid), 64'(oh));
      chk("single_rsp_res",   64'(bus.rsp_res),   64'(exp_res));
      chk("single_rsp_err",   64'(bus.rsp_err),   64'(exp_err));
      chk("single_rsp_a",     f_le_a,             64'd0);
      tick();
   endtask

   initial begin : main
      logic [N-1:0] rr_exp [4];
      rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
      idle_inputs();
      do_reset();

      // Directed operand cases with hand-derived results.
      single(1, F_ONE, F_TWO, 1'b1, 1'b0);
      single(0, F_TWO, F_ONE, 1'b0, 1'b0);
      single(2, F_NAN, F_ONE, 1'b0, 1'b1);

      // Round-robin with all requesters valid and rsp_ready held high.
      do_reset();
      bus.req_valid = '1;
      bus.rsp_ready = '1;
      for (int i = 0; i < N; i++) begin
         bus.req_a[i] = rand_op();
         bus.req_b[i] = rand_op();
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c % 3 == 0) chk("rr_grant", 64'(bus.req_ready), 64'(rr_exp[c / 3]));
         else            chk("rr_idle",  64'(bus.req_ready), 64'd0);
         tick();
      end

      // Stall in RSP, then reset in the middle of it.
      do_reset();
      bus.req_valid = '1;
      bus.rsp_ready = '0;
      @(negedge clk);
      chk("stall_accept", 64'(bus.req_ready), 64'b001);
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'b001);
         chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
         tick();
      end
      rst = 1'b0;
      #1;
      chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
      chk("midrst_busy",      64'(busy),          64'd0);
      chk("midrst_res_err",   64'({bus.rsp_res, bus.rsp_err}), 64'd0);
      chk("midrst_f_le",      f_le_a | f_le_b,    64'd0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_grant", 64'(bus.req_ready), 64'b001);
      tick();
      bus.req_valid = '0;
      bus.rsp_ready = '1;
      repeat (4) tick();

`ifdef F_LE_ARB_LOCK_EN
      // Requester 1 locks the comparator, releases on its third grant.
      begin
         logic [N-1:0] lk_exp [5];
         lk_exp = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100};
         do_reset();
         bus.req_valid = '1;
         bus.rsp_ready = '1;
         bus.req_lock  = 3'b010;
         for (int c = 0; c < 15; c++) begin
            if (c == 9) bus.req_lock = '0;
            @(negedge clk);
            if (c % 3 == 0) chk("lock_grant", 64'(bus.req_ready), 64'(lk_exp[c / 3]));
            tick();
         end
         bus.req_valid = '0;
         bus.req_lock  = '0;
         repeat (4) tick();
      end
`endif

      // Randomized traffic with occasional resets; the model checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         bus.req_valid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            bus.req_a[i] = rand_op();
            bus.req_b[i] = rand_op();
         end
         bus.rsp_ready = ($urandom_range(0, 9) < 7) ? '1 : N'($urandom);
`ifdef F_LE_ARB_LOCK_EN
         bus.req_lock  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
`endif
         rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         tick();
      end
      rst = 1'b1;
      idle_inputs();
      bus.rsp_ready = '1;
      repeat (6) tick();
      chk("txn_count_min", 64'(n_txn > 100), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/f_le_arbiter.md
# f_le_arbiter

Shares one `f_less_or_equal` comparator between `N_REQ` independent requesters, such as several float-sorting FSMs, through per-requester request/response handshakes. Arbitration is round-robin. The block owns the comparator's `f_le_a`/`f_le_b` inputs and registers its `f_le_res`/`f_le_err` outputs. It sits between the requesting FSMs and the single comparator instance in the enclosing design.

## Interface
- `N_REQ`, default 3: number of requesters, minimum 2.
- `FLEN` is not a parameter; it comes from the shared cvw config header (64 for FP64).
- `clk`  in  1  the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester request accept; one-hot or zero.
- `req_a`, `req_b`  in  [N_REQ][FLEN]  operands; the comparison asked is a ≤ b.
- `req_lock`  in  N_REQ  keep the grant after this transaction; present only with `F_LE_ARB_LOCK_EN`.
- `rsp_valid`  out  N_REQ  per-requester response valid; one-hot or zero.
- `rsp_ready`  in  N_REQ  per-requester response accept.
- `rsp_res`  out  1  comparison result; meaningful only while `rsp_valid` is set.
- `rsp_err`  out  1  comparator error (NaN operand).
- `busy`  out  1  high whenever the state is not IDLE.
- `f_le_a`, `f_le_b`  out  FLEN  comparator operands.
- `f_le_res`, `f_le_err`  in  1  comparator outputs.

## Operation
- The FSM has three states: IDLE, CMP and RSP.
- **IDLE:** the picker selects the first requester `i` with `req_valid[i]=1`, scanning from `last_grant+1` modulo N_REQ with wrap-around.
  - `req_ready[i]` is asserted combinationally, in the same cycle.
  - At the clock edge, `req_a[i]` and `req_b[i]` are captured into `op_a`/`op_b`, `grant` is set to `i`, and the state moves to CMP.
  - With no request pending, the FSM stays in IDLE.
- **CMP:** `f_le_a=op_a` and `f_le_b=op_b`.
  - At the edge, `res_q` is loaded with `f_le_res & ~f_le_err` and `err_q` with `f_le_err`.
  - The state moves to RSP.
- **RSP:** `rsp_valid[grant]=1`, `rsp_res=res_q`, `rsp_err=err_q`.
  - When `rsp_ready[grant]=1`: the state moves to IDLE and `last_grant` is set to `grant`.
  - Otherwise the FSM holds in RSP with all outputs stable.
- Outside CMP, `f_le_a` and `f_le_b` are all-zero.
- Outside RSP, `rsp_valid`, `rsp_res` and `rsp_err` are 0.
- `req_ready` is zero outside IDLE.
- `rsp_ready` bits of requesters not currently granted are ignored.
- A requester may drop `req_valid` before it is granted; this has no side effect.
- An error is not sticky: it is reported per transaction only.

## Timing
- **Reset:** state IDLE, `last_grant=N_REQ-1` (requester 0 has highest priority), `op_a`/`op_b`/`res_q`/`err_q`/`grant` = 0, locked = 0. Every output is 0.
- **Reset mid-transaction:** the transaction is discarded with no response, and the next cycle after reset release is IDLE.
- **Latency:** for an accept in cycle t, `rsp_valid` is high in cycle t+2.
- **Throughput:** one comparison per 3 cycles when `rsp_ready` is held high.
- **Comparator path:** the comparator is treated as combinational; its result is sampled only in the CMP cycle.
- **Round-robin fairness:** with all requesters valid continuously, grant order is 0,1,2,0,… and no requester waits more than N_REQ transactions.
- **Back-pressure:** while RSP stalls, no new request is accepted.

## Configuration
- **`F_LE_ARB_LOCK_EN` defined:** the `req_lock` port exists.
  - `req_lock[grant]` is sampled at acceptance into `locked`.
  - While `locked=1`, IDLE grants only `last_grant` and the other requesters wait.
  - `locked` clears when a transaction from that requester is accepted with `req_lock=0`.
  - Lets a sorting FSM perform several comparisons back-to-back without interleaving.
  - `busy` is also high while `locked=1`.
- **Undefined:** no `req_lock` port, pure round-robin, no `locked` register.

## Structure
- Package `f_le_arb_pkg` holds:
  - the state enum `f_le_arb_state_t` (IDLE/CMP/RSP);
  - the grant-index width, `$clog2(N_REQ)`, as a function/localparam.
- Sub-module `f_le_rr_pick`: a combinational round-robin picker.
  - Inputs: request vector, `last_grant`, and optional force-index/force-enable for lock.
  - Outputs: one-hot grant and grant index.
- Everything else lives in `f_le_arbiter`.

## Test plan
FP64 constants: 1.0 = 64'h3FF0000000000000, 2.0 = 64'h4000000000000000, NaN = 64'h7FF8000000000000. Tests use `N_REQ=3`.
- **Single request:** req 1 with a=1.0, b=2.0, `rsp_ready` high → accept in cycle t; `rsp_valid=3'b010`, `rsp_res=1`, `rsp_err=0` at t+2; `f_le_a=1.0` only in t+1.
- **Reversed operands:** req 0 with a=2.0, b=1.0 → `rsp_res=0`, `rsp_err=0`.
- **NaN operand:** req 2 with a=NaN, b=1.0 → `rsp_res=0`, `rsp_err=1`.
- **Round-robin:** all three requesters valid continuously → grants 0,1,2,0 at cycles 0,3,6,9.
- **Stall and reset:** `rsp_ready` low for 5 cycles → RSP held and `req_ready=0`; then assert `rst=0` mid-RSP → all outputs 0 immediately, and requester 0 wins first after release.
- **Lock (`F_LE_ARB_LOCK_EN`):** req 1 accepted with `req_lock=1` while 0 and 2 are valid → the next two grants go to 1; after req 1 is accepted with `req_lock=0`, the next grant goes to 2.
